// File: rtl/thermo_pkg.sv
// Shared types for the thermometer-code scanner: FSM state encoding and default widths.
package thermo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ERR_W_DEFAULT = 8;

endpackage

// File: rtl/thermo_scanner_if.sv
// Word-in / classification-out handshake bundle between a producer/consumer and the scanner.
interface thermo_scanner_if #(
    parameter int W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         din;
    logic                 out_valid;
    logic                 out_ready;
    logic                 is_thermo;
    logic [$clog2(W):0]   level;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, is_thermo, level
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, is_thermo, level
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/thermo_scanner.sv
// Serial thermometer-code classifier: one adjacent-bit pair per cycle, stops at the second transition.
// Result appears W-1 edges after accept (or j+1 for an early stop at pair j) and is held until taken.
module thermo_scanner
    import thermo_pkg::*;
#(
    parameter int W     = 16,
    parameter int ERR_W = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    thermo_scanner_if.slave  bus,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int KW = $clog2(W);
    localparam int LW = KW + 1;

    state_t         state;
    logic [W-1:0]   word;
    logic [KW-1:0]  k;
    logic [KW-1:0]  kp1;
    logic [1:0]     tcnt;
    logic [1:0]     tcnt_nxt;
    logic [LW-1:0]  first_lvl;
    logic [LW-1:0]  lvl_nxt;
    logic           trans;
    logic           last;
    logic           err_inc;

    assign kp1   = k + KW'(1);
    assign trans = word[k] ^ word[kp1];

    // Transition count saturates at 2; reaching 2 is what triggers the early stop.
    always_comb begin
        tcnt_nxt = tcnt;
        if (trans && (tcnt != 2'd2)) begin
            tcnt_nxt = tcnt + 2'd1;
        end
        lvl_nxt = first_lvl;
        if (trans && (tcnt == 2'd0)) begin
            lvl_nxt = LW'(kp1);
        end
        last = (k == KW'(W - 2)) || (tcnt_nxt == 2'd2);
    end

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            word          <= '0;
            k             <= '0;
            tcnt          <= '0;
            first_lvl     <= '0;
            bus.out_valid <= 1'b0;
            bus.is_thermo <= 1'b0;
            bus.level     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        word      <= bus.din;
                        k         <= '0;
                        tcnt      <= '0;
                        first_lvl <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    tcnt      <= tcnt_nxt;
                    first_lvl <= lvl_nxt;
                    k         <= kp1;
                    if (last) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.is_thermo <= (tcnt_nxt == 2'd1);
                        bus.level     <= (tcnt_nxt == 2'd1) ? lvl_nxt : '0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.is_thermo <= 1'b0;
                        bus.level     <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign err_inc = bus.out_valid & bus.out_ready & ~bus.is_thermo;

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr_err),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_thermo_scanner.sv
// Scoreboard bench for thermo_scanner: expected results queued at accept, compared at the out handshake.
module tb_thermo_scanner;

    localparam int W     = 16;
    localparam int ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        logic th;
        int   lvl;
        int   lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr_err = 1'b0;
    logic [ERR_W-1:0] err_cnt;

    thermo_scanner_if #(.W(W)) bus ();

    thermo_scanner #(
        .W     (W),
        .ERR_W (ERR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clr_err (clr_err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   err_model = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d);
        exp_t e;
        int   tc;
        tc    = 0;
        e.lvl = 0;
        e.lat = W - 1;
        for (int i = 0; i < W - 1; i++) begin
            if (d[i] != d[i+1]) begin
                tc++;
                if (tc == 1) e.lvl = i + 1;
                if (tc == 2) begin
                    e.lat = i + 1;
                    break;
                end
            end
        end
        e.th = (tc == 1);
        if (!e.th) e.lvl = 0;
        return e;
    endfunction

    // Drive one word at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [W-1:0] d, input bit verbose);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
        bus.din      = d;
        bus.in_valid = 1'b1;
        sb.push_back(model(d));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.din      = W'($urandom);
        if (verbose) begin
            check("scan_in_ready", bus.in_ready, 0);
            check("scan_is_thermo", bus.is_thermo, 0);
            check("scan_level", bus.level, 0);
        end
    endtask

    task automatic collect(input int stall, input bit clr);
        int   lat;
        exp_t e;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("is_thermo", bus.is_thermo, e.th);
        check("level", bus.level, e.lvl);
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.din       = W'($urandom);
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_is_thermo", bus.is_thermo, e.th);
            check("stall_level", bus.level, e.lvl);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr_err       = clr;
        @(negedge clk);
        bus.out_ready = 1'b0;
        clr_err       = 1'b0;
        if (clr) err_model = 0;
        else if (!e.th && err_model < ERR_MAX) err_model++;
        check("err_cnt", err_cnt, err_model);
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] one;
        int           seen;
        one          = 1;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_is_thermo", bus.is_thermo, 0);
        check("rst_level", bus.level, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);

        // Directed words: full scans, early stops, both code polarities, all-zero/all-one.
        send(16'h00FF, 1); collect(0, 0);
        send(16'h0000, 1); collect(0, 0);
        send(16'h0F0F, 1); collect(0, 0);
        send(16'hFFFE, 1); collect(5, 0);
        send(16'h8000, 1); collect(0, 0);
        send(16'h7FFF, 1); collect(0, 0);
        send(16'h0001, 1); collect(1, 0);
        send(16'hFFFF, 1); collect(0, 0);
        send(16'h5555, 1); collect(0, 0);

        // Saturate the error counter with early-stopping invalid words.
        for (int i = 0; i < 256; i++) begin
            d      = W'($urandom);
            d[3:0] = 4'b0101;
            send(d, 0);
            collect(0, 0);
        end
        check("err_saturated", err_cnt, ERR_MAX);
        send(16'h0000, 1); collect(0, 1);
        check("err_cleared", err_cnt, 0);

        // Reset in the middle of a scan drops the word entirely.
        send(16'h0000, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_err_cnt", err_cnt, err_model);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        check("midrst_err_hold", err_cnt, err_model);

        // Random mix of genuine thermometer codes and arbitrary words.
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                d = (one << $urandom_range(1, W - 1)) - one;
                if ($urandom_range(0, 1) == 1) d = ~d;
            end else begin
                d = W'($urandom);
            end
            send(d, 0);
            collect($urandom_range(0, 2), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thermo_scanner.md
THERMO_SCANNER -- requirements
Module: thermo_scanner

Interface
REQ-001 SHALL have parameter W, default 16, meaning input word width (W >= 4).
REQ-002 SHALL have parameter ERR_W, default 8, meaning error counter width.
REQ-003 SHALL have port clk  input  1  single clock for all state, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  din carries a word to scan.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port din  input  W  word to classify.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port is_thermo  output  1  word had exactly one adjacent-bit transition.
REQ-011 SHALL have port level  output  $clog2(W)+1  LSB-side run length when is_thermo, else 0.
REQ-012 SHALL have port err_cnt  output  ERR_W  saturating count of non-thermometer results delivered.
REQ-013 SHALL have port clr_err  input  1  synchronous clear of err_cnt.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept, SHALL latch din, clear transition count and pair index k to 0, and go to SCAN.
REQ-017 In SCAN, SHALL evaluate one pair per cycle: transition if din[k] != din[k+1], then k increments.
REQ-018 On the first transition at pair k, SHALL record level = k+1.
REQ-019 SHALL go to DONE after evaluating pair W-2, or immediately after evaluating the pair that gives a second transition, whichever comes first.
REQ-020 For a full scan, out_valid SHALL rise on the (W-1)th rising edge after the accepting edge; for an early stop at pair j, on edge j+1.
REQ-021 is_thermo SHALL equal (transition count == 1); all-zeros and all-ones words are non-thermometer; both rising and falling codes qualify.
REQ-022 level SHALL be 0 whenever is_thermo = 0.
REQ-023 out_valid, is_thermo, and level SHALL be registered and held stable in DONE until out_valid & out_ready.
REQ-024 On the out handshake, SHALL return to IDLE; in_ready rises the following cycle, so there is no same-cycle re-accept.
REQ-025 in_valid and din SHALL be ignored outside IDLE.
REQ-026 On each out handshake with is_thermo = 0, err_cnt SHALL increment by 1 and saturate at 2^ERR_W-1.
REQ-027 clr_err SHALL clear err_cnt to 0 at the next edge; clr_err takes priority over a simultaneous increment.
REQ-028 is_thermo and level SHALL read 0 outside DONE.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE, in_ready 1 after release, out_valid 0, is_thermo 0, level 0, err_cnt 0, k 0, transition count 0.
REQ-030 Reset asserted mid-SCAN or mid-DONE SHALL discard the in-flight word with no result and no err_cnt change.

Structure
REQ-031 Shared package thermo_pkg SHALL hold the state enum (IDLE/SCAN/DONE) and default ERR_W constant.
REQ-032 A sub-module sat_counter (parameter width, inc, clr, async rst) SHALL implement err_cnt.
REQ-033 The transition counter SHALL be 2 bits wide and saturate at 2.

Verification (W=16)
REQ-034 din=16'h00FF accepted -> out_valid on 15th edge, is_thermo=1, level=8, err_cnt unchanged.
REQ-035 din=16'h0000 -> out_valid on 15th edge, is_thermo=0, level=0, err_cnt +1 on handshake.
REQ-036 din=16'h0F0F -> second transition at pair 7, out_valid on edge 8, is_thermo=0.
REQ-037 din=16'hFFFE with out_ready low 5 cycles -> outputs stable (is_thermo=1, level=1), in_ready=0 throughout, in_valid pulses ignored.
REQ-038 256 invalid words -> err_cnt=255; then clr_err with a simultaneous invalid handshake -> err_cnt=0.
REQ-039 rst pulsed at SCAN cycle 5 -> out_valid=0 immediately, in_ready=1 after release, no result emitted.
